// File: rtl/wait_meter_tiered.sv
`default_nettype none
// ============================================================================
// Module   : wait_meter_tiered
// Purpose  : Tiered taxi waiting-time meter. Counts clock cycles while the
//            vehicle is stopped, completes a billing period every CNT_PERIOD
//            stopped cycles, and adds the selected tier price to a saturating
//            total once the free grace allowance has been used up. A partial
//            period carries over across stops; clear starts a new trip.
// Options  : WAIT_METER_CAP_EN - clamp the total at PRICE_CAP instead of at
//            the full-scale value of DW bits.
// Revision : 1.0 - initial release
// ============================================================================
module wait_meter_tiered #(
    parameter int                  DW            = 32,
    parameter int                  CW            = 16,
    parameter int                  STAGES        = 3,
    parameter int                  SW            = (STAGES > 1) ? $clog2(STAGES) : 1,
    parameter int                  CNT_PERIOD    = 100,
    parameter int                  GRACE_PERIODS = 0,
    parameter logic [STAGES*DW-1:0] PRICE_VEC    = {32'd10, 32'd7, 32'd0},
    parameter logic [DW-1:0]       PRICE_CAP     = {DW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          stopping,
    input  logic [SW-1:0] stage_idx,
    output logic [DW-1:0] total_price,
    output logic [CW-1:0] period_count,
    output logic          tick,
    output logic          saturated
);

    // Derived operating mode; nothing extra is stored, it follows from
    // stopping and how many periods have already completed.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRACE = 2'd1;
    localparam logic [1:0] S_BILL  = 2'd2;

    localparam logic [CW-1:0] c_cnt_last = CW'(CNT_PERIOD - 1);
    localparam logic [CW-1:0] c_grace    = CW'(GRACE_PERIODS);
`ifdef WAIT_METER_CAP_EN
    // PRICE_CAP is already DW bits wide, so it can never exceed 2^DW-1.
    localparam logic [DW-1:0] c_limit = PRICE_CAP;
`else
    localparam logic [DW-1:0] c_limit = {DW{1'b1}};
`endif

    logic [CW-1:0] r_cyc;
    logic [CW-1:0] r_period_count;
    logic [DW-1:0] r_total_price;
    logic          r_tick;
    logic          r_saturated;

    logic [1:0]    w_state;
    logic [DW-1:0] w_price;
    logic [DW:0]   w_sum;
    logic          w_done;
    logic [CW-1:0] w_cyc_nxt;
    logic [CW-1:0] w_period_count_nxt;
    logic [DW-1:0] w_total_price_nxt;
    logic          w_tick_nxt;
    logic          w_saturated_nxt;

    // Mode decode, tier price lookup and next-state computation.
    always_comb begin
        w_price = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (stage_idx == SW'(i)) w_price = PRICE_VEC[i*DW +: DW];
        end

        if (!stopping)                     w_state = S_IDLE;
        else if (r_period_count < c_grace) w_state = S_GRACE;
        else                               w_state = S_BILL;

        w_done = stopping && (r_cyc == c_cnt_last);
        w_sum  = {1'b0, r_total_price} + {1'b0, w_price};

        w_cyc_nxt          = r_cyc;
        w_period_count_nxt = r_period_count;
        w_total_price_nxt  = r_total_price;
        w_tick_nxt         = 1'b0;
        w_saturated_nxt    = r_saturated;

        case (w_state)
            S_GRACE, S_BILL: begin
                if (w_done) begin
                    w_cyc_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    if (r_period_count != {CW{1'b1}})
                        w_period_count_nxt = r_period_count + 1'b1;
                    if (w_state == S_BILL) begin
                        if (w_sum > {1'b0, c_limit}) begin
                            w_total_price_nxt = c_limit;
                            w_saturated_nxt   = 1'b1;
                        end else begin
                            w_total_price_nxt = w_sum[DW-1:0];
                        end
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: ; // idle: cycle count holds so a partial period carries over
        endcase
    end

    // State registers; clear wins over counting and discards the current cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc          <= '0;
            r_period_count <= '0;
            r_total_price  <= '0;
            r_tick         <= 1'b0;
            r_saturated    <= 1'b0;
        end else if (clear) begin
            r_cyc          <= '0;
            r_period_count <= '0;
            r_total_price  <= '0;
            r_tick         <= 1'b0;
            r_saturated    <= 1'b0;
        end else begin
            r_cyc          <= w_cyc_nxt;
            r_period_count <= w_period_count_nxt;
            r_total_price  <= w_total_price_nxt;
            r_tick         <= w_tick_nxt;
            r_saturated    <= w_saturated_nxt;
        end
    end

    assign total_price  = r_total_price;
    assign period_count = r_period_count;
    assign tick         = r_tick;
    assign saturated    = r_saturated;

endmodule
`default_nettype wire
